// File: rtl/local_memory_bank_arbiter_if.sv
// Single-master bus into the local memory bank arbiter: byte address, lane selects,
// request/write strobes, 32-bit data in both directions and a stall back to the master.
interface local_memory_bank_arbiter_if #(
  parameter int ADDRESS_SIZE = 24
);
  logic [ADDRESS_SIZE-1:0] address;
  logic [3:0]              byteSelect;
  logic                    enable;
  logic                    writeEnable;
  logic [31:0]             dataWrite;
  logic [31:0]             dataRead;
  logic                    busy;

  modport master (
    output address, byteSelect, enable, writeEnable, dataWrite,
    input  dataRead, busy
  );

  modport slave (
    input  address, byteSelect, enable, writeEnable, dataWrite,
    output dataRead, busy
  );
endinterface

// File: rtl/local_memory_bank_arbiter.sv
// Dual-master front end for 2**BLOCK_ADDRESS_SIZE banks of 1RW+1R SRAM macros.
// Optional anti-starvation guard for the secondary master: LOCAL_MEMORY_STALL_GUARD_EN.
module local_memory_bank_arbiter #(
  parameter int ADDRESS_SIZE       = 24,
  parameter int SRAM_ADDRESS_SIZE  = 9,
  parameter int BLOCK_ADDRESS_SIZE = 2
`ifdef LOCAL_MEMORY_STALL_GUARD_EN
  , parameter int STALL_LIMIT      = 4
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst,
  local_memory_bank_arbiter_if.slave            primary,
  local_memory_bank_arbiter_if.slave            secondary,
  output logic                                  clk0,
  output logic [(1<<BLOCK_ADDRESS_SIZE)-1:0]    csb0,
  output logic                                  web0,
  output logic [3:0]                            wmask0,
  output logic [SRAM_ADDRESS_SIZE-1:0]          addr0,
  output logic [31:0]                           din0,
  input  logic [32*(1<<BLOCK_ADDRESS_SIZE)-1:0] dout0,
  output logic                                  clk1,
  output logic [(1<<BLOCK_ADDRESS_SIZE)-1:0]    csb1,
  output logic [SRAM_ADDRESS_SIZE-1:0]          addr1,
  input  logic [32*(1<<BLOCK_ADDRESS_SIZE)-1:0] dout1
);
  localparam int BLOCK_COUNT = 1 << BLOCK_ADDRESS_SIZE;
  localparam int BANK_W      = (BLOCK_ADDRESS_SIZE > 0) ? BLOCK_ADDRESS_SIZE : 1;
  localparam int WORD_TOP    = SRAM_ADDRESS_SIZE + BLOCK_ADDRESS_SIZE + 2;

  logic [BANK_W-1:0]            primaryBank, secondaryBank;
  logic [BANK_W-1:0]            primaryBankReg, secondaryBankReg;
  logic [3:0]                   primarySelectReg, secondarySelectReg;
  logic                         primaryInRange, secondaryInRange;
  logic                         primaryReadReady, secondaryReadReady;
  logic [BLOCK_COUNT-1:0]       primaryOneHot, secondaryOneHot;
  logic [SRAM_ADDRESS_SIZE-1:0] primaryMacroAddress, secondaryMacroAddress;
  logic [31:0]                  primaryWord, secondaryWord;
  logic [31:0]                  primaryReadData, secondaryReadData;
  logic                         unusedByteOffset;

  assign clk0 = clk;
  assign clk1 = clk;
  assign unusedByteOffset = ^{primary.address[1:0], secondary.address[1:0]};

  assign primaryMacroAddress   = primary.address[SRAM_ADDRESS_SIZE+1:2];
  assign secondaryMacroAddress = secondary.address[SRAM_ADDRESS_SIZE+1:2];
  assign addr1                 = primaryMacroAddress;

  generate
    if (BLOCK_ADDRESS_SIZE > 0) begin : gBankIndex
      assign primaryBank   = primary.address[WORD_TOP-1:SRAM_ADDRESS_SIZE+2];
      assign secondaryBank = secondary.address[WORD_TOP-1:SRAM_ADDRESS_SIZE+2];
    end else begin : gSingleBank
      assign primaryBank   = '0;
      assign secondaryBank = '0;
    end
    if (WORD_TOP < ADDRESS_SIZE) begin : gRangeCheck
      assign primaryInRange   = ~|primary.address[ADDRESS_SIZE-1:WORD_TOP];
      assign secondaryInRange = ~|secondary.address[ADDRESS_SIZE-1:WORD_TOP];
    end else begin : gFullRange
      assign primaryInRange   = 1'b1;
      assign secondaryInRange = 1'b1;
    end
  endgenerate

  logic primaryRead, primaryWrite, primaryIssueRead;
  logic secondaryRead, secondaryWrite, secondaryNeedsPort;
  logic guardFire, primaryOwnsPort, secondaryGranted, secondaryStalled;

  assign primaryRead      = primary.enable && primaryInRange && !primary.writeEnable;
  assign primaryWrite     = primary.enable && primaryInRange && primary.writeEnable;
  assign primaryIssueRead = primaryRead && !primaryReadReady;

  assign secondaryRead      = secondary.enable && secondaryInRange && !secondary.writeEnable;
  assign secondaryWrite     = secondary.enable && secondaryInRange && secondary.writeEnable;
  // The second cycle of a secondary read only consumes dout0, not the RW port.
  assign secondaryNeedsPort = secondaryWrite || (secondaryRead && !secondaryReadReady);

`ifdef LOCAL_MEMORY_STALL_GUARD_EN
  logic [3:0] stallCount;
  assign guardFire = secondaryNeedsPort && primaryWrite && (stallCount >= 4'(STALL_LIMIT));
`else
  assign guardFire = 1'b0;
`endif

  assign primaryOwnsPort  = primaryWrite && !guardFire;
  assign secondaryGranted = secondaryNeedsPort && !primaryOwnsPort;
  assign secondaryStalled = secondaryNeedsPort && primaryOwnsPort;

  assign primary.busy   = !rst && ((primaryWrite && guardFire) || primaryIssueRead);
  assign secondary.busy = !rst && (secondaryStalled || (secondaryRead && !secondaryReadReady));

  always_comb begin
    primaryOneHot   = '0;
    secondaryOneHot = '0;
    primaryWord     = '1;
    secondaryWord   = '1;
    for (int unsigned i = 0; i < BLOCK_COUNT; i++) begin
      primaryOneHot[i]   = (primaryBank == BANK_W'(i));
      secondaryOneHot[i] = (secondaryBank == BANK_W'(i));
      if (primaryBankReg == BANK_W'(i))   primaryWord   = dout1[i*32 +: 32];
      if (secondaryBankReg == BANK_W'(i)) secondaryWord = dout0[i*32 +: 32];
    end
  end

  always_comb begin
    primaryReadData   = '1;
    secondaryReadData = '1;
    for (int unsigned l = 0; l < 4; l++) begin
      if (!rst && primaryReadReady && primaryRead && primarySelectReg[l])
        primaryReadData[l*8 +: 8] = primaryWord[l*8 +: 8];
      if (!rst && secondaryReadReady && secondaryRead && secondarySelectReg[l])
        secondaryReadData[l*8 +: 8] = secondaryWord[l*8 +: 8];
    end
  end

  assign primary.dataRead   = primaryReadData;
  assign secondary.dataRead = secondaryReadData;

  always_ff @(posedge clk) begin
    if (rst) begin
      primaryReadReady   <= 1'b0;
      secondaryReadReady <= 1'b0;
      primaryBankReg     <= '0;
      secondaryBankReg   <= '0;
      primarySelectReg   <= '0;
      secondarySelectReg <= '0;
`ifdef LOCAL_MEMORY_STALL_GUARD_EN
      stallCount         <= '0;
`endif
    end else begin
      primaryReadReady   <= primaryIssueRead;
      secondaryReadReady <= secondaryRead && secondaryGranted;
      if (primaryIssueRead) begin
        primaryBankReg   <= primaryBank;
        primarySelectReg <= primary.byteSelect;
      end
      if (secondaryRead && secondaryGranted) begin
        secondaryBankReg   <= secondaryBank;
        secondarySelectReg <= secondary.byteSelect;
      end
`ifdef LOCAL_MEMORY_STALL_GUARD_EN
      stallCount <= secondaryStalled ? stallCount + 4'd1 : '0;
`endif
    end
  end

  // Macro controls launch mid-cycle so the SRAM captures them on the following rising edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      csb0   <= '1;
      csb1   <= '1;
      web0   <= 1'b1;
      wmask0 <= '0;
      addr0  <= '0;
      din0   <= '0;
    end else begin
      csb1 <= primaryIssueRead ? ~primaryOneHot : '1;
      if (primaryOwnsPort) begin
        csb0   <= ~primaryOneHot;
        web0   <= 1'b0;
        wmask0 <= primary.byteSelect;
        addr0  <= primaryMacroAddress;
        din0   <= primary.dataWrite;
      end else if (secondaryGranted) begin
        csb0   <= ~secondaryOneHot;
        web0   <= !secondary.writeEnable;
        wmask0 <= secondary.byteSelect;
        addr0  <= secondaryMacroAddress;
        din0   <= secondary.dataWrite;
      end else begin
        csb0 <= '1;
        web0 <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_local_memory_bank_arbiter.sv
// Directed bench for local_memory_bank_arbiter with a behavioural 1RW+1R SRAM per bank.
// Macros are 256 words deep here so the bank index falls on address bits [11:10].
module tb_local_memory_bank_arbiter;
  localparam int AS = 24;
  localparam int SAS = 8;
  localparam int BAS = 2;
  localparam int BC = 1 << BAS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  local_memory_bank_arbiter_if #(.ADDRESS_SIZE(AS)) primaryBus ();
  local_memory_bank_arbiter_if #(.ADDRESS_SIZE(AS)) secondaryBus ();

  logic          clk0, clk1, web0;
  logic [BC-1:0] csb0, csb1;
  logic [3:0]    wmask0;
  logic [SAS-1:0] addr0, addr1;
  logic [31:0]   din0;
  logic [32*BC-1:0] dout0, dout1;

  local_memory_bank_arbiter #(
    .ADDRESS_SIZE(AS), .SRAM_ADDRESS_SIZE(SAS), .BLOCK_ADDRESS_SIZE(BAS)
  ) dut (
    .clk(clk), .rst(rst), .primary(primaryBus), .secondary(secondaryBus),
    .clk0(clk0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0), .clk1(clk1), .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  // Behavioural SRAM: word (bank b, address a) powers up as 32'hC0DE_b0aa.
  logic [31:0] mem [BC][256];
  always @(posedge clk) begin
    for (int b = 0; b < BC; b++) begin
      if (rst) begin
        for (int a = 0; a < 256; a++) mem[b][a] <= {16'hC0DE, 4'(b), 4'h0, 8'(a)};
      end else begin
        if (!csb0[b]) begin
          if (!web0) begin
            for (int l = 0; l < 4; l++)
              if (wmask0[l]) mem[b][addr0][l*8 +: 8] <= din0[l*8 +: 8];
          end else begin
            dout0[b*32 +: 32] <= mem[b][addr0];
          end
        end
        if (!csb1[b]) dout1[b*32 +: 32] <= mem[b][addr1];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    primaryBus.enable = 1'b0; primaryBus.writeEnable = 1'b0;
    primaryBus.address = '0; primaryBus.byteSelect = 4'h0; primaryBus.dataWrite = '0;
    secondaryBus.enable = 1'b0; secondaryBus.writeEnable = 1'b0;
    secondaryBus.address = '0; secondaryBus.byteSelect = 4'h0; secondaryBus.dataWrite = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleAll();
    nextCycle();
    nextCycle();
    #6;
    checks++; if (csb0 !== 4'hF) begin errors++; $display("FAIL rst_csb0 got %h want f", csb0); end
    checks++; if (csb1 !== 4'hF) begin errors++; $display("FAIL rst_csb1 got %h want f", csb1); end
    checks++; if (web0 !== 1'b1) begin errors++; $display("FAIL rst_web0 got %b want 1", web0); end
    checks++; if (wmask0 !== 4'h0) begin errors++; $display("FAIL rst_wmask0 got %h want 0", wmask0); end
    checks++; if (primaryBus.dataRead !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_pdata got %h want ffffffff", primaryBus.dataRead); end
    checks++; if (secondaryBus.dataRead !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_sdata got %h want ffffffff", secondaryBus.dataRead); end
    checks++; if (primaryBus.busy !== 1'b0 || secondaryBus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b%b want 00", primaryBus.busy, secondaryBus.busy); end
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  task automatic test_write_read();
    primaryBus.address = 24'h000404; primaryBus.dataWrite = 32'hDEADBEEF;
    primaryBus.byteSelect = 4'hF; primaryBus.writeEnable = 1'b1; primaryBus.enable = 1'b1;
    #6;
    checks++; if (primaryBus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy got %b want 0", primaryBus.busy); end
    checks++; if (csb0 !== 4'b1101) begin errors++; $display("FAIL wr_csb0 got %b want 1101", csb0); end
    checks++; if (web0 !== 1'b0 || wmask0 !== 4'hF) begin errors++; $display("FAIL wr_web_mask got %b/%h want 0/f", web0, wmask0); end
    checks++; if (addr0 !== 8'h01 || din0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_addr_din got %h/%h want 01/deadbeef", addr0, din0); end
    nextCycle();
    primaryBus.writeEnable = 1'b0; primaryBus.byteSelect = 4'h3;
    #6;
    checks++; if (primaryBus.busy !== 1'b1) begin errors++; $display("FAIL rd1_busy got %b want 1", primaryBus.busy); end
    checks++; if (csb1 !== 4'b1101 || addr1 !== 8'h01) begin errors++; $display("FAIL rd1_csb1 got %b/%h want 1101/01", csb1, addr1); end
    checks++; if (csb0 !== 4'hF) begin errors++; $display("FAIL rd1_csb0 got %b want 1111", csb0); end
    nextCycle();
    #6;
    checks++; if (primaryBus.busy !== 1'b0) begin errors++; $display("FAIL rd2_busy got %b want 0", primaryBus.busy); end
    checks++; if (primaryBus.dataRead !== 32'hFFFFBEEF) begin errors++; $display("FAIL rd2_data got %h want ffffbeef", primaryBus.dataRead); end
    checks++; if (csb1 !== 4'hF) begin errors++; $display("FAIL rd2_csb1 got %b want 1111", csb1); end
    nextCycle();
    idleAll();
    #6;
    checks++; if (primaryBus.dataRead !== 32'hFFFFFFFF) begin errors++; $display("FAIL rd_idle_data got %h want ffffffff", primaryBus.dataRead); end
    nextCycle();
  endtask

  task automatic test_secondary_read();
    secondaryBus.address = 24'h000C08; secondaryBus.byteSelect = 4'hF;
    secondaryBus.writeEnable = 1'b0; secondaryBus.enable = 1'b1;
    #6;
    checks++; if (secondaryBus.busy !== 1'b1) begin errors++; $display("FAIL srd1_busy got %b want 1", secondaryBus.busy); end
    checks++; if (csb0 !== 4'b0111 || web0 !== 1'b1 || addr0 !== 8'h02) begin
      errors++; $display("FAIL srd1_port got %b/%b/%h want 0111/1/02", csb0, web0, addr0); end
    nextCycle();
    #6;
    checks++; if (secondaryBus.busy !== 1'b0) begin errors++; $display("FAIL srd2_busy got %b want 0", secondaryBus.busy); end
    checks++; if (secondaryBus.dataRead !== 32'hC0DE3002) begin errors++; $display("FAIL srd2_data got %h want c0de3002", secondaryBus.dataRead); end
    nextCycle();
    idleAll();
    nextCycle();
  endtask

  task automatic test_dual_read();
    primaryBus.address = 24'h000808; primaryBus.byteSelect = 4'hF; primaryBus.enable = 1'b1;
    secondaryBus.address = 24'h000004; secondaryBus.byteSelect = 4'b1100; secondaryBus.enable = 1'b1;
    #6;
    checks++; if (primaryBus.busy !== 1'b1 || secondaryBus.busy !== 1'b1) begin
      errors++; $display("FAIL dual1_busy got %b%b want 11", primaryBus.busy, secondaryBus.busy); end
    checks++; if (csb1 !== 4'b1011 || csb0 !== 4'b1110) begin errors++; $display("FAIL dual1_csb got %b/%b want 1011/1110", csb1, csb0); end
    nextCycle();
    #6;
    checks++; if (primaryBus.busy !== 1'b0 || secondaryBus.busy !== 1'b0) begin
      errors++; $display("FAIL dual2_busy got %b%b want 00", primaryBus.busy, secondaryBus.busy); end
    checks++; if (primaryBus.dataRead !== 32'hC0DE2002) begin errors++; $display("FAIL dual2_pdata got %h want c0de2002", primaryBus.dataRead); end
    checks++; if (secondaryBus.dataRead !== 32'hC0DEFFFF) begin errors++; $display("FAIL dual2_sdata got %h want c0deffff", secondaryBus.dataRead); end
    nextCycle();
    #6;
    checks++; if (primaryBus.busy !== 1'b1 || secondaryBus.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_busy got %b%b want 11", primaryBus.busy, secondaryBus.busy); end
    nextCycle();
    #6;
    checks++; if (primaryBus.dataRead !== 32'hC0DE2002 || secondaryBus.dataRead !== 32'hC0DEFFFF) begin
      errors++; $display("FAIL b2b_data got %h/%h want c0de2002/c0deffff", primaryBus.dataRead, secondaryBus.dataRead); end
    nextCycle();
    idleAll();
    nextCycle();
  endtask

  task automatic test_drop_mid_read();
    primaryBus.address = 24'h000808; primaryBus.byteSelect = 4'hF; primaryBus.enable = 1'b1;
    nextCycle();
    primaryBus.enable = 1'b0;
    #6;
    checks++; if (primaryBus.busy !== 1'b0 || primaryBus.dataRead !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL drop_out got %b/%h want 0/ffffffff", primaryBus.busy, primaryBus.dataRead); end
    nextCycle();
    primaryBus.enable = 1'b1;
    #6;
    checks++; if (primaryBus.busy !== 1'b1) begin errors++; $display("FAIL drop_restart_busy got %b want 1", primaryBus.busy); end
    nextCycle();
    #6;
    checks++; if (primaryBus.dataRead !== 32'hC0DE2002) begin errors++; $display("FAIL drop_restart_data got %h want c0de2002", primaryBus.dataRead); end
    nextCycle();
    idleAll();
    nextCycle();
  endtask

  task automatic test_stall_guard();
    logic       expP, expS;
    logic [3:0] expCsb;
    primaryBus.address = 24'h000010; primaryBus.byteSelect = 4'hF;
    primaryBus.writeEnable = 1'b1; primaryBus.enable = 1'b1;
    secondaryBus.address = 24'h00040C; secondaryBus.dataWrite = 32'h12345678;
    secondaryBus.byteSelect = 4'hF; secondaryBus.writeEnable = 1'b1; secondaryBus.enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      primaryBus.dataWrite = 32'(k);
      #6;
`ifdef LOCAL_MEMORY_STALL_GUARD_EN
      expP = (k == 5); expS = (k != 5); expCsb = (k == 5) ? 4'b1101 : 4'b1110;
`else
      expP = 1'b0; expS = 1'b1; expCsb = 4'b1110;
`endif
      checks++; if (primaryBus.busy !== expP || secondaryBus.busy !== expS) begin
        errors++; $display("FAIL stall%0d_busy got %b%b want %b%b", k, primaryBus.busy, secondaryBus.busy, expP, expS); end
      checks++; if (csb0 !== expCsb || web0 !== 1'b0) begin
        errors++; $display("FAIL stall%0d_port got %b/%b want %b/0", k, csb0, web0, expCsb); end
      nextCycle();
    end
    idleAll();
    nextCycle();
  endtask

  task automatic test_out_of_range();
    primaryBus.address = 24'h040000; primaryBus.byteSelect = 4'hF; primaryBus.enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #6;
      checks++; if (primaryBus.busy !== 1'b0 || primaryBus.dataRead !== 32'hFFFFFFFF) begin
        errors++; $display("FAIL oor%0d_out got %b/%h want 0/ffffffff", k, primaryBus.busy, primaryBus.dataRead); end
      checks++; if (csb1 !== 4'hF) begin errors++; $display("FAIL oor%0d_csb1 got %b want 1111", k, csb1); end
      nextCycle();
    end
    idleAll();
    nextCycle();
  endtask

  task automatic test_reset_mid_read();
    primaryBus.address = 24'h000808; primaryBus.byteSelect = 4'hF; primaryBus.enable = 1'b1;
    #6;
    checks++; if (csb1 !== 4'b1011) begin errors++; $display("FAIL rmr_issue_csb1 got %b want 1011", csb1); end
    nextCycle();
    rst = 1'b1;
    #6;
    checks++; if (csb1 !== 4'hF || csb0 !== 4'hF) begin errors++; $display("FAIL rmr_csb got %b/%b want 1111/1111", csb1, csb0); end
    checks++; if (primaryBus.busy !== 1'b0 || primaryBus.dataRead !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL rmr_out got %b/%h want 0/ffffffff", primaryBus.busy, primaryBus.dataRead); end
    nextCycle();
    rst = 1'b0;
    #6;
    checks++; if (primaryBus.busy !== 1'b1) begin errors++; $display("FAIL rmr_restart_busy got %b want 1", primaryBus.busy); end
    nextCycle();
    idleAll();
    nextCycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idleAll();
    test_reset();
    test_write_read();
    test_secondary_read();
    test_dual_read();
    test_drop_mid_read();
    test_stall_guard();
    test_out_of_range();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
